// File: rtl/spu_evt_rx_pkg.sv
// Shared definitions for the SPU event receiver: privilege encoding, register map
// and the CTRL register layout.
package spu_evt_rx_pkg;

    localparam int unsigned CfgAddrW = 3;
    localparam int unsigned CfgDataW = 32;

    localparam logic [1:0] PrivNone = 2'b00;
    localparam logic [1:0] PrivM    = 2'b01;
    localparam logic [1:0] PrivS    = 2'b10;
    localparam logic [1:0] PrivU    = 2'b11;

    localparam logic [CfgAddrW-1:0] AddrCtrl   = 3'd0;
    localparam logic [CfgAddrW-1:0] AddrAsid   = 3'd1;
    localparam logic [CfgAddrW-1:0] AddrStatus = 3'd2;
    localparam logic [CfgAddrW-1:0] AddrThresh = 3'd3;
    localparam logic [CfgAddrW-1:0] AddrCount0 = 3'd4;

    typedef struct packed {
        logic       irq_en;     // [10]
        logic       sid_en;     // [9]
        logic       sid;        // [8]
        logic       asid_en;    // [7]
        logic [2:0] priv_mask;  // [6:4] = {U, S, M}
        logic [3:0] en;         // [3:0]
    } ctrl_t;

    // An event passes only with a valid privilege whose mask bit is set.
    function automatic logic priv_ok(logic [1:0] priv, logic [2:0] mask);
        case (priv)
            PrivM:   return mask[0];
            PrivS:   return mask[1];
            PrivU:   return mask[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spu_evt_rx_if.sv
// Register access bus of the SPU event receiver; the host drives requests, the
// receiver grants them and returns read data one cycle later.
interface spu_evt_rx_if;
    import spu_evt_rx_pkg::*;

    logic                req;
    logic                we;
    logic [CfgAddrW-1:0] addr;
    logic [CfgDataW-1:0] wdata;
    logic                gnt;
    logic                rvalid;
    logic [CfgDataW-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/spu_evt_cnt.sv
// Saturating per-line event counter with load; reports overflow and threshold hits
// for the increment it is about to apply.
module spu_evt_cnt #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 inc_i,
    input  logic [CNT_WIDTH-1:0] thresh_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o,
    output logic                 thr_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 at_max;
    logic                 do_inc;

    // A load in the same cycle suppresses the increment and both flags.
    assign at_max = &cnt_q;
    assign do_inc = inc_i & ~load_i;
    assign ovf_o  = do_inc & at_max;
    assign thr_o  = do_inc & ~at_max & (thresh_i != '0) & ((cnt_q + CNT_WIDTH'(1)) == thresh_i);
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (do_inc && !at_max) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/spu_evt_rx.sv
// SPU event receiver: registers incoming event pulses, filters them against CTRL/ASID
// and counts accepted events per line, with a small register file for configuration.
module spu_evt_rx
    import spu_evt_rx_pkg::*;
#(
    parameter int unsigned ASID_WIDTH = 16,
    parameter int unsigned NUM_LINES  = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_LINES-1:0]  e_id_i,
    input  logic [ASID_WIDTH+1:0] e_info_i,
    input  logic                  s_id_i,
    spu_evt_rx_if.slave           cfg,
    output logic                  irq_o
);

    ctrl_t                  ctrl_q;
    logic [ASID_WIDTH-1:0]  asid_q;
    logic [NUM_LINES-1:0]   ovf_q, thr_q, ovf_d, thr_d;
    logic [CfgDataW-1:0]    thresh_q;
    logic [NUM_LINES-1:0]   e_id_q;
    logic [ASID_WIDTH+1:0]  e_info_q;
    logic                   s_id_q;
    logic                   rvalid_q;
    logic [CfgDataW-1:0]    rdata_q, rd_val;

    logic                   wr, rd, evt_ok;
    logic [NUM_LINES-1:0]   inc, load, ovf_set, thr_set, w1c_ovf, w1c_thr;
    logic [CNT_WIDTH-1:0]   cnt [NUM_LINES];

    assign wr         = cfg.req & cfg.we;
    assign rd         = cfg.req & ~cfg.we;
    assign cfg.gnt    = cfg.req;
    assign cfg.rvalid = rvalid_q;
    assign cfg.rdata  = rdata_q;

    // Stage 2 filter uses the live CTRL, so a CTRL write applies to events already in stage 1.
    always_comb begin
        evt_ok = priv_ok(e_info_q[ASID_WIDTH +: 2], ctrl_q.priv_mask)
               & (~ctrl_q.asid_en | (e_info_q[ASID_WIDTH-1:0] == asid_q))
               & (~ctrl_q.sid_en | (s_id_q == ctrl_q.sid));
        inc    = e_id_q & ctrl_q.en & {NUM_LINES{evt_ok}};
    end

    for (genvar n = 0; n < NUM_LINES; n++) begin : g_cnt
        assign load[n] = wr & (cfg.addr == AddrCount0 + 3'(n));

        spu_evt_cnt #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .load_i     (load[n]),
            .load_val_i (cfg.wdata[CNT_WIDTH-1:0]),
            .inc_i      (inc[n]),
            .thresh_i   (CNT_WIDTH'(thresh_q)),
            .cnt_o      (cnt[n]),
            .ovf_o      (ovf_set[n]),
            .thr_o      (thr_set[n])
        );
    end

    // New sets take priority over a W1C of the same bit.
    always_comb begin
        w1c_ovf = '0;
        w1c_thr = '0;
        if (wr && cfg.addr == AddrStatus) begin
            w1c_ovf = cfg.wdata[NUM_LINES-1:0];
            w1c_thr = cfg.wdata[2*NUM_LINES-1:NUM_LINES];
        end
        ovf_d = (ovf_q & ~w1c_ovf) | ovf_set;
        thr_d = (thr_q & ~w1c_thr) | thr_set;
    end

    always_comb begin
        rd_val = '0;
        case (cfg.addr)
            AddrCtrl:   rd_val = CfgDataW'(ctrl_q);
            AddrAsid:   rd_val = CfgDataW'(asid_q);
            AddrStatus: rd_val = CfgDataW'({thr_q, ovf_q});
            AddrThresh: rd_val = thresh_q;
            default:    rd_val = CfgDataW'(cnt[cfg.addr[1:0]]);
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_q   <= '0;
            asid_q   <= '0;
            ovf_q    <= '0;
            thr_q    <= '0;
            thresh_q <= '0;
            e_id_q   <= '0;
            e_info_q <= '0;
            s_id_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            irq_o    <= 1'b0;
        end else begin
            e_id_q   <= e_id_i;
            e_info_q <= e_info_i;
            s_id_q   <= s_id_i;
            if (wr && cfg.addr == AddrCtrl)   ctrl_q   <= ctrl_t'(cfg.wdata[$bits(ctrl_t)-1:0]);
            if (wr && cfg.addr == AddrAsid)   asid_q   <= cfg.wdata[ASID_WIDTH-1:0];
            if (wr && cfg.addr == AddrThresh) thresh_q <= cfg.wdata;
            ovf_q    <= ovf_d;
            thr_q    <= thr_d;
            irq_o    <= ctrl_q.irq_en & (|{thr_q, ovf_q});
            rvalid_q <= rd;
            rdata_q  <= rd ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_spu_evt_rx.sv
// Directed bench for spu_evt_rx; expected read data is queued when a read is issued
// and compared when the response arrives.
module tb_spu_evt_rx;
    import spu_evt_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [3:0]  e_id;
    logic [17:0] e_info;
    logic        s_id;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    spu_evt_rx_if cfg_if ();

    spu_evt_rx #(
        .ASID_WIDTH (16),
        .NUM_LINES  (4),
        .CNT_WIDTH  (32)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .e_id_i   (e_id),
        .e_info_i (e_info),
        .s_id_i   (s_id),
        .cfg      (cfg_if),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; a read sampled at this edge must answer right after it.
    task automatic step();
        logic        was_rd;
        logic [31:0] exp;
        string       tag;
        #2;
        chk("gnt", 32'(cfg_if.gnt), 32'(cfg_if.req));
        was_rd = cfg_if.req & ~cfg_if.we & rst_ni;
        @(posedge clk);
        #1;
        if (was_rd) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            chk({tag, "_rvalid"}, 32'(cfg_if.rvalid), 32'd1);
            chk(tag, cfg_if.rdata, exp);
        end else begin
            chk("idle_rvalid", 32'(cfg_if.rvalid), 32'd0);
            chk("idle_rdata", cfg_if.rdata, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        cfg_if.req   = 1'b1;
        cfg_if.we    = 1'b1;
        cfg_if.addr  = addr;
        cfg_if.wdata = data;
        step();
        cfg_if.req   = 1'b0;
        cfg_if.we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        cfg_if.req  = 1'b1;
        cfg_if.we   = 1'b0;
        cfg_if.addr = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        step();
        cfg_if.req  = 1'b0;
    endtask

    task automatic evt(input logic [3:0] id, input logic [1:0] priv, input logic [15:0] asid,
                       input logic sid);
        e_id   = id;
        e_info = {priv, asid};
        s_id   = sid;
        step();
        e_id   = '0;
    endtask

    initial begin
        rst_ni       = 1'b0;
        e_id         = '0;
        e_info       = '0;
        s_id         = 1'b0;
        cfg_if.req   = 1'b0;
        cfg_if.we    = 1'b0;
        cfg_if.addr  = '0;
        cfg_if.wdata = '0;
        idle(2);
        rst_ni = 1'b1;

        // Reset state of every register, back-to-back reads.
        for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("reset_reg%0d", a));
        chk("reset_irq", 32'(irq), 32'd0);

        // All privileges enabled, ten M events on line 2.
        wr(AddrCtrl, 32'h07F);
        for (int i = 0; i < 10; i++) evt(4'b0100, PrivM, 16'h0, 1'b0);
        idle(1);
        rd(AddrCount0 + 3'd2, 32'd10, "filt_cnt2");
        rd(AddrCount0 + 3'd0, 32'd0, "filt_cnt0");
        rd(AddrCount0 + 3'd1, 32'd0, "filt_cnt1");
        rd(AddrCount0 + 3'd3, 32'd0, "filt_cnt3");
        rd(AddrCtrl, 32'h07F, "ctrl_rb");

        // Only M privilege accepted.
        wr(AddrCtrl, 32'h01F);
        for (int i = 0; i < 5; i++) evt(4'b0001, PrivM, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) evt(4'b0001, PrivU, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) evt(4'b0001, PrivNone, 16'h0, 1'b0);
        idle(1);
        rd(AddrCount0, 32'd5, "priv_cnt0");

        // ASID match required.
        wr(AddrAsid, 32'h0042);
        wr(AddrCtrl, 32'h0FF);
        for (int i = 0; i < 8; i++) evt(4'b0010, PrivS, (i % 2 == 0) ? 16'h0042 : 16'h0043, 1'b0);
        idle(1);
        rd(AddrCount0 + 3'd1, 32'd4, "asid_cnt1");
        wr(AddrAsid, 32'hFFFF_0042);
        rd(AddrAsid, 32'h0000_0042, "asid_unused_bits");

        // Source id must equal CTRL.sid=1.
        wr(AddrCtrl, 32'h37F);
        evt(4'b1000, PrivU, 16'h0, 1'b0);
        evt(4'b1000, PrivU, 16'h0, 1'b1);
        evt(4'b1000, PrivU, 16'h0, 1'b1);
        idle(1);
        rd(AddrCount0 + 3'd3, 32'd2, "sid_cnt3");

        // Saturation sets ovf and raises irq one cycle after STATUS.
        wr(AddrCtrl, 32'hFFFF_FC7F);
        rd(AddrCtrl, 32'h47F, "ctrl_unused_bits");
        wr(AddrCount0 + 3'd3, 32'hFFFF_FFFF);
        evt(4'b1000, PrivM, 16'h0, 1'b0);
        idle(1);
        chk("sat_irq_early", 32'(irq), 32'd0);
        idle(1);
        chk("sat_irq", 32'(irq), 32'd1);
        rd(AddrCount0 + 3'd3, 32'hFFFF_FFFF, "sat_cnt3");
        rd(AddrStatus, 32'h008, "sat_status");
        wr(AddrStatus, 32'h008);
        idle(1);
        chk("w1c_irq", 32'(irq), 32'd0);
        rd(AddrStatus, 32'h000, "w1c_status");

        // Threshold hit on line 0.
        wr(AddrCtrl, 32'h07F);
        wr(AddrThresh, 32'd3);
        wr(AddrCount0, 32'd0);
        for (int i = 0; i < 3; i++) evt(4'b0001, PrivM, 16'h0, 1'b0);
        idle(1);
        rd(AddrStatus, 32'h010, "thr_status");
        rd(AddrCount0, 32'd3, "thr_cnt0");

        // Count write collides with increment: write wins.
        evt(4'b0001, PrivM, 16'h0, 1'b0);
        wr(AddrCount0, 32'd100);
        idle(1);
        rd(AddrCount0, 32'd100, "load_wins_cnt0");

        // W1C collides with a new threshold set: bit stays.
        wr(AddrStatus, 32'h0FF);
        rd(AddrStatus, 32'h000, "w1c_all");
        wr(AddrCount0, 32'd2);
        evt(4'b0001, PrivM, 16'h0, 1'b0);
        wr(AddrStatus, 32'h010);
        idle(1);
        rd(AddrStatus, 32'h010, "w1c_vs_set");
        rd(AddrCount0, 32'd3, "w1c_vs_set_cnt0");

        // Reset coinciding with a granted read, then a write issued during reset.
        cfg_if.req  = 1'b1;
        cfg_if.we   = 1'b0;
        cfg_if.addr = AddrCount0;
        rst_ni      = 1'b0;
        step();
        cfg_if.we    = 1'b1;
        cfg_if.addr  = AddrCtrl;
        cfg_if.wdata = 32'h47F;
        step();
        cfg_if.req = 1'b0;
        cfg_if.we  = 1'b0;
        rst_ni     = 1'b1;
        for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("post_rst_reg%0d", a));
        chk("post_rst_irq", 32'(irq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
